// File: rtl/seq_mem_d2_be_if.sv
// Bus bundle for seq_mem_d2_be: request fields driven by the master, completion pulses by the memory.
// Handshake: read_en/write_en are one-cycle requests that are always accepted (there is no ready);
// each request is answered by a one-cycle read_done/write_done pulse at a fixed latency.
interface seq_mem_d2_be_if #(
    parameter int WIDTH       = 32,
    parameter int D0_IDX_SIZE = 3,
    parameter int D1_IDX_SIZE = 3
);
    logic [D0_IDX_SIZE-1:0] addr0;
    logic [D1_IDX_SIZE-1:0] addr1;
    logic                   read_en;
    logic [WIDTH-1:0]       out;
    logic                   read_done;
    logic [WIDTH-1:0]       in;
    logic                   write_en;
    logic [WIDTH/8-1:0]     write_mask;
    logic                   write_done;
    logic                   oob_err;

    modport master (
        output addr0, addr1, read_en, in, write_en, write_mask,
        input  out, read_done, write_done, oob_err
    );

    modport slave (
        input  addr0, addr1, read_en, in, write_en, write_mask,
        output out, read_done, write_done, oob_err
    );
endinterface

// File: rtl/seq_mem_d2_be.sv
// Two-dimensional word memory with per-byte write mask, read-first collisions and
// a read path of one or two register stages (READ_LAT).
module seq_mem_d2_be #(
    parameter int WIDTH       = 32,
    parameter int D0_SIZE     = 4,
    parameter int D1_SIZE     = 4,
    parameter int D0_IDX_SIZE = 3,
    parameter int D1_IDX_SIZE = 3,
    parameter int READ_LAT    = 1
) (
    input logic             clk,
    input logic             reset_n,
    seq_mem_d2_be_if.slave  bus
);
    localparam int DEPTH = D0_SIZE * D1_SIZE;
    localparam int NB    = WIDTH / 8;
    localparam int LIN_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             oob;
    logic [LIN_W-1:0] lin;
    logic [WIDTH-1:0] rd_word;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    // Reads and writes share one address, so one bounds check serves both.
    always_comb begin
        oob     = (32'(bus.addr0) >= D0_SIZE) || (32'(bus.addr1) >= D1_SIZE);
        lin     = LIN_W'(32'(bus.addr0) * D1_SIZE + 32'(bus.addr1));
        rd_word = oob ? '0 : mem[lin];
    end

    // Storage has no reset; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (reset_n && bus.write_en && !oob) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.write_mask[b]) begin
                    mem[lin][8*b +: 8] <= bus.in[8*b +: 8];
                end
            end
        end
    end

    // rd_word is taken before the write lands, which gives read-first on a collision.
    // Any READ_LAT other than 1 is treated as 2.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            bus.out        <= '0;
            bus.read_done  <= 1'b0;
            bus.write_done <= 1'b0;
            bus.oob_err    <= 1'b0;
        end else begin
            bus.write_done <= bus.write_en;
            bus.oob_err    <= oob && (bus.read_en || bus.write_en);
            s1_valid       <= bus.read_en;
            s1_data        <= rd_word;
            if (READ_LAT == 1) begin
                bus.read_done <= bus.read_en;
                if (bus.read_en) begin
                    bus.out <= rd_word;
                end
            end else begin
                bus.read_done <= s1_valid;
                if (s1_valid) begin
                    bus.out <= s1_data;
                end
            end
        end
    end
endmodule
